// File: rtl/plab3_mem_cache_req_arbiter.sv
// ----------------------------------------------------------------------------
// plab3_mem_cache_req_arbiter
//
// Merges the core request stream and the coherence request stream onto the
// single cache request port. Coherence traffic has no back-pressure, so any
// coherence request that cannot go straight through is parked in a small FIFO
// and replayed from there with priority over the core.
//
// Optional feature: define PLAB3_MEM_CACHE_ARB_FAIRNESS_EN to compile in a
// starvation guard. After p_max_streak coherence transfers while the core is
// waiting, the next grant goes to the core. Without the macro, coherence
// priority is strict.
//
// Ports
//   clk            sole clock, rising edge
//   reset          asynchronous active-low reset
//   corereq_msg    core request message (zero-extended to p_msg_nbits)
//   corereq_val    core request valid
//   corereq_rdy    core request ready (combinational)
//   coherereq_msg  coherence request message
//   coherereq_val  coherence request valid (always accepted)
//   arbreq_msg     request message to the cache (zero when arbreq_val is low)
//   arbreq_val     request valid to the cache
//   arbreq_rdy     cache ready
//   req_sel        granted source: 0 core, 1 coherence bypass, 2 coherence buffered
//   coh_overflow   sticky: a coherence request was dropped on a full buffer
//   coh_count      coherence buffer occupancy
//
// FSM
//   state | meaning
//   ARB   | grant chosen combinationally each cycle
//   HOLD  | previous grant stalled; output held on the registered source
// ----------------------------------------------------------------------------
module plab3_mem_cache_req_arbiter #(
    parameter int p_msg_nbits  = 175,
    parameter int p_coh_depth  = 2,
    parameter int p_max_streak = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [p_msg_nbits-1:0]        corereq_msg,
    input  logic                          corereq_val,
    output logic                          corereq_rdy,
    input  logic [p_msg_nbits-1:0]        coherereq_msg,
    input  logic                          coherereq_val,
    output logic [p_msg_nbits-1:0]        arbreq_msg,
    output logic                          arbreq_val,
    input  logic                          arbreq_rdy,
    output logic [1:0]                    req_sel,
    output logic                          coh_overflow,
    output logic [$clog2(p_coh_depth):0]  coh_count
);

    localparam int PW = $clog2(p_coh_depth);
    localparam int CW = PW + 1;

    localparam logic [0:0] ARB  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    localparam logic [1:0] SEL_CORE = 2'd0;
    localparam logic [1:0] SEL_BYP  = 2'd1;
    localparam logic [1:0] SEL_BUF  = 2'd2;

    if (p_coh_depth < 2 || (p_coh_depth & (p_coh_depth - 1)) != 0) begin : g_bad_depth
        $error("p_coh_depth must be a power of two and at least 2");
    end
    if (p_max_streak < 1) begin : g_bad_streak
        $error("p_max_streak must be at least 1");
    end

    logic [0:0]             state;
    logic [1:0]             held_sel;
    logic [p_msg_nbits-1:0] held_msg;

    logic [p_msg_nbits-1:0] mem [p_coh_depth];
    logic [PW-1:0]          head;
    logic [PW-1:0]          tail;
    logic [CW-1:0]          count;
    logic                   overflow;

    logic                   buf_nonempty;
    logic                   buf_full;
    logic                   core_first;

    logic [1:0]             sel;
    logic                   val;
    logic [p_msg_nbits-1:0] msg;
    logic                   xfer;
    logic                   bypass_taken;
    logic                   enq;
    logic                   deq;
    logic                   enq_ok;
    logic                   drop;

    assign buf_nonempty = (count != '0);
    assign buf_full     = (count == CW'(p_coh_depth));

`ifdef PLAB3_MEM_CACHE_ARB_FAIRNESS_EN
    localparam int SW = $clog2(p_max_streak + 1);
    logic [SW-1:0] streak;

    assign core_first = corereq_val && (streak == SW'(p_max_streak));

    // Saturates at p_max_streak so the core stays favoured until it is served.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak <= '0;
        end else if (!corereq_val) begin
            streak <= '0;
        end else if (xfer && sel == SEL_CORE) begin
            streak <= '0;
        end else if (xfer && streak != SW'(p_max_streak)) begin
            streak <= streak + SW'(1);
        end
    end
`else
    assign core_first = 1'b0;
`endif

    // Grant selection. Reset forces the port idle so nothing leaks out while
    // the block is held in reset.
    always_comb begin
        sel = SEL_CORE;
        val = 1'b0;
        msg = '0;
        if (state == HOLD) begin
            val = 1'b1;
            sel = held_sel;
            msg = (held_sel == SEL_BUF) ? mem[head] : held_msg;
        end else if (core_first) begin
            val = 1'b1;
            sel = SEL_CORE;
            msg = corereq_msg;
        end else if (buf_nonempty) begin
            val = 1'b1;
            sel = SEL_BUF;
            msg = mem[head];
        end else if (coherereq_val) begin
            val = 1'b1;
            sel = SEL_BYP;
            msg = coherereq_msg;
        end else if (corereq_val) begin
            val = 1'b1;
            sel = SEL_CORE;
            msg = corereq_msg;
        end
        if (!reset) begin
            sel = SEL_CORE;
            val = 1'b0;
            msg = '0;
        end
    end

    assign xfer         = val && arbreq_rdy;
    assign bypass_taken = (state == ARB) && (sel == SEL_BYP) && arbreq_rdy;

    // A coherence request that does not leave through the bypass this cycle is
    // parked, including a bypass grant the cache refused.
    assign enq    = reset && coherereq_val && !bypass_taken;
    assign deq    = xfer && (sel == SEL_BUF);
    assign enq_ok = enq && (!buf_full || deq);
    assign drop   = enq && buf_full && !deq;

    assign arbreq_msg   = msg;
    assign arbreq_val   = val;
    assign req_sel      = sel;
    assign corereq_rdy  = xfer && (sel == SEL_CORE);
    assign coh_overflow = overflow;
    assign coh_count    = count;

    always_ff @(posedge clk) begin
        if (enq_ok) begin
            mem[tail] <= coherereq_msg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ARB;
            held_sel <= SEL_CORE;
            held_msg <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (enq_ok) begin
                tail <= tail + PW'(1);
            end
            if (deq) begin
                head <= head + PW'(1);
            end
            count <= count + CW'(enq_ok) - CW'(deq);
            if (drop) begin
                overflow <= 1'b1;
            end
            case (state)
                ARB: begin
                    if (val && !arbreq_rdy) begin
                        state    <= HOLD;
                        // A refused bypass now sits at the buffer head (the
                        // buffer was empty), so it is held as a buffered grant.
                        held_sel <= (sel == SEL_BYP) ? SEL_BUF : sel;
                        held_msg <= msg;
                    end
                end
                HOLD: begin
                    if (arbreq_rdy) begin
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_plab3_mem_cache_req_arbiter.sv
module tb_plab3_mem_cache_req_arbiter;

    localparam int W = 175;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  corereq_msg;
    logic          corereq_val;
    logic          corereq_rdy;
    logic [W-1:0]  coherereq_msg;
    logic          coherereq_val;
    logic [W-1:0]  arbreq_msg;
    logic          arbreq_val;
    logic          arbreq_rdy;
    logic [1:0]    req_sel;
    logic          coh_overflow;
    logic [1:0]    coh_count;

    always #5 clk = ~clk;

    plab3_mem_cache_req_arbiter #(
        .p_msg_nbits (W),
        .p_coh_depth (2),
        .p_max_streak(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .corereq_msg  (corereq_msg),
        .corereq_val  (corereq_val),
        .corereq_rdy  (corereq_rdy),
        .coherereq_msg(coherereq_msg),
        .coherereq_val(coherereq_val),
        .arbreq_msg   (arbreq_msg),
        .arbreq_val   (arbreq_val),
        .arbreq_rdy   (arbreq_rdy),
        .req_sel      (req_sel),
        .coh_overflow (coh_overflow),
        .coh_count    (coh_count)
    );

    typedef struct {
        logic         cv;
        logic [W-1:0] cm;
        logic         hv;
        logic [W-1:0] hm;
        logic         rdy;
        logic         ev;
        logic [1:0]   es;
        logic [W-1:0] em;
        logic         ecr;
    } vec_t;

    typedef struct {
        logic [1:0]   sel;
        logic [W-1:0] msg;
    } xfer_t;

    xfer_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic expect_xfer(input logic [1:0] s, input logic [W-1:0] m);
        xfer_t e;
        e.sel = s;
        e.msg = m;
        sb.push_back(e);
    endtask

    task automatic drive(input logic cv, input logic [W-1:0] cm, input logic hv,
                         input logic [W-1:0] hm, input logic r);
        corereq_val   = cv;
        corereq_msg   = cm;
        coherereq_val = hv;
        coherereq_msg = hm;
        arbreq_rdy    = r;
    endtask

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic ev, input logic [1:0] es,
                              input logic [W-1:0] em, input logic ecr);
        check({tag, "_val"}, W'(arbreq_val), W'(ev));
        check({tag, "_sel"}, W'(req_sel), W'(es));
        check({tag, "_msg"}, arbreq_msg, em);
        check({tag, "_core_rdy"}, W'(corereq_rdy), W'(ecr));
    endtask

    task automatic expect_cnt(input string tag, input logic [1:0] ec, input logic eo);
        check({tag, "_count"}, W'(coh_count), W'(ec));
        check({tag, "_overflow"}, W'(coh_overflow), W'(eo));
    endtask

    // Scoreboard: every accepted transfer must match the next expected one.
    xfer_t got;
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (!arbreq_val) check("msg_zero_when_idle", arbreq_msg, '0);
            if (arbreq_val && arbreq_rdy) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got transfer sel=%0d msg=%h, required no transfer",
                             req_sel, arbreq_msg);
                end else begin
                    got = sb.pop_front();
                    check("sb_sel", W'(req_sel), W'(got.sel));
                    check("sb_msg", arbreq_msg, got.msg);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

    vec_t         vecs[8];
    logic [W-1:0] wide_a;
    logic [W-1:0] fmsg;

    initial begin
        wide_a = {7{25'h1ABCDEF}};
        //              cv    cm      hv    hm       rdy   ev    es     em      ecr
        vecs[0] = '{1'b1, W'('hA5), 1'b0, '0,       1'b1, 1'b1, 2'd0, W'('hA5), 1'b1};
        vecs[1] = '{1'b0, '0,       1'b0, '0,       1'b1, 1'b0, 2'd0, '0,       1'b0};
        vecs[2] = '{1'b0, '0,       1'b1, W'('h3C), 1'b1, 1'b1, 2'd1, W'('h3C), 1'b0};
        vecs[3] = '{1'b1, W'('h11), 1'b1, W'('h22), 1'b1, 1'b1, 2'd1, W'('h22), 1'b0};
        vecs[4] = '{1'b1, W'('h11), 1'b0, '0,       1'b1, 1'b1, 2'd0, W'('h11), 1'b1};
        vecs[5] = '{1'b1, wide_a,   1'b0, '0,       1'b1, 1'b1, 2'd0, wide_a,   1'b1};
        vecs[6] = '{1'b0, '0,       1'b1, ~wide_a,  1'b1, 1'b1, 2'd1, ~wide_a,  1'b0};
        vecs[7] = '{1'b0, '0,       1'b0, W'('h99), 1'b1, 1'b0, 2'd0, '0,       1'b0};

        // Reset state, with traffic present on every input.
        reset = 1'b0;
        drive(1'b1, W'('hA5), 1'b1, W'('h5A), 1'b1);
        next_cyc();
        #2;
        expect_out("reset", 1'b0, 2'd0, '0, 1'b0);
        expect_cnt("reset", 2'd0, 1'b0);
        next_cyc();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        next_cyc();

        // Single-cycle grant table, buffer empty, cache always ready.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].cv, vecs[i].cm, vecs[i].hv, vecs[i].hm, vecs[i].rdy);
            #2;
            expect_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].es, vecs[i].em, vecs[i].ecr);
            if (vecs[i].ev && vecs[i].rdy) expect_xfer(vecs[i].es, vecs[i].em);
            next_cyc();
        end
        #2;
        expect_cnt("table_end", 2'd0, 1'b0);
        next_cyc();

        // Full buffer with simultaneous enqueue and dequeue across the wrap.
        drive(1'b0, '0, 1'b1, W'('hD1), 1'b0); #2;
        expect_out("wrap_c1", 1'b1, 2'd1, W'('hD1), 1'b0); expect_cnt("wrap_c1", 2'd0, 1'b0);
        next_cyc();
        drive(1'b0, '0, 1'b1, W'('hD2), 1'b0); #2;
        expect_out("wrap_c2", 1'b1, 2'd2, W'('hD1), 1'b0); expect_cnt("wrap_c2", 2'd1, 1'b0);
        next_cyc();
        drive(1'b0, '0, 1'b1, W'('hD3), 1'b1); #2;
        expect_out("wrap_c3", 1'b1, 2'd2, W'('hD1), 1'b0); expect_cnt("wrap_c3", 2'd2, 1'b0);
        expect_xfer(2'd2, W'('hD1));
        next_cyc();
        drive(1'b0, '0, 1'b1, W'('hD4), 1'b1); #2;
        expect_out("wrap_c4", 1'b1, 2'd2, W'('hD2), 1'b0); expect_cnt("wrap_c4", 2'd2, 1'b0);
        expect_xfer(2'd2, W'('hD2));
        next_cyc();
        drive(1'b0, '0, 1'b0, '0, 1'b1); #2;
        expect_out("wrap_c5", 1'b1, 2'd2, W'('hD3), 1'b0); expect_cnt("wrap_c5", 2'd2, 1'b0);
        expect_xfer(2'd2, W'('hD3));
        next_cyc();
        #2;
        expect_out("wrap_c6", 1'b1, 2'd2, W'('hD4), 1'b0); expect_cnt("wrap_c6", 2'd1, 1'b0);
        expect_xfer(2'd2, W'('hD4));
        next_cyc();
        #2;
        expect_out("wrap_c7", 1'b0, 2'd0, '0, 1'b0); expect_cnt("wrap_c7", 2'd0, 1'b0);
        next_cyc();

        // Refused bypass held for three cycles; third arrival overflows.
        drive(1'b0, '0, 1'b1, W'('hC1), 1'b0); #2;
        expect_out("hold_c1", 1'b1, 2'd1, W'('hC1), 1'b0); expect_cnt("hold_c1", 2'd0, 1'b0);
        next_cyc();
        drive(1'b0, '0, 1'b1, W'('hC2), 1'b0); #2;
        expect_out("hold_c2", 1'b1, 2'd2, W'('hC1), 1'b0); expect_cnt("hold_c2", 2'd1, 1'b0);
        next_cyc();
        drive(1'b0, '0, 1'b1, W'('hC3), 1'b0); #2;
        expect_out("hold_c3", 1'b1, 2'd2, W'('hC1), 1'b0); expect_cnt("hold_c3", 2'd2, 1'b0);
        next_cyc();
        drive(1'b0, '0, 1'b0, '0, 1'b1); #2;
        expect_out("hold_c4", 1'b1, 2'd2, W'('hC1), 1'b0); expect_cnt("hold_c4", 2'd2, 1'b1);
        expect_xfer(2'd2, W'('hC1));
        next_cyc();
        #2;
        expect_out("hold_c5", 1'b1, 2'd2, W'('hC2), 1'b0); expect_cnt("hold_c5", 2'd1, 1'b1);
        expect_xfer(2'd2, W'('hC2));
        next_cyc();
        #2;
        expect_out("hold_c6", 1'b0, 2'd0, '0, 1'b0); expect_cnt("hold_c6", 2'd0, 1'b1);
        next_cyc();

        // Reset mid-HOLD with two entries buffered.
        drive(1'b0, '0, 1'b1, W'('hE1), 1'b0); #2;
        expect_out("rst_c1", 1'b1, 2'd1, W'('hE1), 1'b0);
        next_cyc();
        drive(1'b0, '0, 1'b1, W'('hE2), 1'b0); #2;
        expect_out("rst_c2", 1'b1, 2'd2, W'('hE1), 1'b0);
        next_cyc();
        drive(1'b0, '0, 1'b0, '0, 1'b0); #2;
        expect_out("rst_c3", 1'b1, 2'd2, W'('hE1), 1'b0); expect_cnt("rst_c3", 2'd2, 1'b1);
        reset = 1'b0;
        #1;
        expect_out("rst_now", 1'b0, 2'd0, '0, 1'b0); expect_cnt("rst_now", 2'd0, 1'b0);
        next_cyc();
        next_cyc();
        reset = 1'b1;
        drive(1'b1, W'('h77), 1'b0, '0, 1'b1); #2;
        expect_out("rst_new", 1'b1, 2'd0, W'('h77), 1'b1); expect_cnt("rst_new", 2'd0, 1'b0);
        expect_xfer(2'd0, W'('h77));
        next_cyc();
        drive(1'b0, '0, 1'b0, '0, 1'b1); #2;
        expect_out("rst_idle", 1'b0, 2'd0, '0, 1'b0); expect_cnt("rst_idle", 2'd0, 1'b0);
        next_cyc();

        // Continuous coherence traffic with the core waiting.
`ifdef PLAB3_MEM_CACHE_ARB_FAIRNESS_EN
        for (int i = 0; i < 5; i++) begin
            fmsg = W'(32'h100 + i);
            drive(1'b1, W'('hC0), 1'b1, fmsg, 1'b1); #2;
            if (i < 4) begin
                expect_out($sformatf("fair%0d", i), 1'b1, 2'd1, fmsg, 1'b0);
                expect_xfer(2'd1, fmsg);
            end else begin
                expect_out($sformatf("fair%0d", i), 1'b1, 2'd0, W'('hC0), 1'b1);
                expect_xfer(2'd0, W'('hC0));
            end
            next_cyc();
        end
        drive(1'b0, '0, 1'b0, '0, 1'b1); #2;
        expect_out("fair_drain", 1'b1, 2'd2, W'(32'h104), 1'b0);
        expect_xfer(2'd2, W'(32'h104));
        next_cyc();
`else
        for (int i = 0; i < 8; i++) begin
            fmsg = W'(32'h100 + i);
            drive(1'b1, W'('hC0), 1'b1, fmsg, 1'b1); #2;
            expect_out($sformatf("strict%0d", i), 1'b1, 2'd1, fmsg, 1'b0);
            expect_xfer(2'd1, fmsg);
            next_cyc();
        end
        drive(1'b0, '0, 1'b0, '0, 1'b1);
`endif
        #2;
        expect_out("final_idle", 1'b0, 2'd0, '0, 1'b0); expect_cnt("final_idle", 2'd0, 1'b0);
        next_cyc();
        check("sb_drained", W'(sb.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
